opl_write_sequencer: RTL and testbench
======================================

# opl_write_sequencer

Sits between the UART byte receiver and the jtopl core in the OPL2 playback path. Pairs the incoming serial byte stream into (register, value) writes, buffers them in a FIFO, and issues each write to the OPL as an address cycle followed by a data cycle. Each cycle is held for a fixed number of clocks and followed by a wait that meets OPL2 bus recovery times. This makes write timing independent of the host's byte rate, so bursts faster than 115200 baud no longer violate OPL write spacing.

## Interface
Parameters:
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW pairs.
- `WR_HOLD`, 56: clocks that `opl_cs_n` is held low per bus cycle (≥1; 56 = 2 OPL clocks at 100 MHz).
- `ADDR_WAIT`, 336: idle clocks after the address cycle (12 OPL clocks).
- `DATA_WAIT`, 2352: idle clocks after the data cycle (84 OPL clocks).
- `ACT_BITS`, 22: width of the activity stretch counter (used only with the configuration macro).

Ports:
- `clk` in 1: system clock (100 MHz domain). Single clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: one-cycle strobe; `in_data` is valid.
- `in_data` in 8: received byte.
- `in_eop` in 1: end-of-packet strobe from the receiver; realigns pairing.
- `opl_cs_n` out 1: OPL chip select, active low.
- `opl_addr` out 1: 0 = register-address cycle, 1 = data cycle.
- `opl_din` out 8: OPL bus data.
- `busy` out 1: state ≠ IDLE or FIFO not empty.
- `level` out FIFO_AW+1: pairs currently stored.
- `overflow` out 1: sticky; set when a pair is dropped because the FIFO is full.
- `led` out 1: activity indicator.

## Operation
- **Pairing.** `phase` flag, reset 0.
  - When `in_valid` and `phase`=0: latch `in_data` as the register number and set `phase`=1.
  - When `in_valid` and `phase`=1: push {reg, `in_data`} into the FIFO and clear `phase`.
  - `in_eop` clears `phase`; a pending lone register byte is discarded.
  - If `in_eop` and `in_valid` occur in the same cycle, the byte is processed first, then `phase` is forced to 0.
- **FIFO.** Synchronous, 2^FIFO_AW × 16 bits.
  - Full and empty are evaluated from the pre-edge `level`.
  - A push while full is dropped and sets `overflow`, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle, when not full, leave `level` unchanged.
- **FSM.** States: IDLE, AWR, AWAIT, DWR, DWAIT.
  - IDLE: if the FIFO is not empty, pop and go to AWR.
  - AWR: `opl_cs_n`=0, `opl_addr`=0, `opl_din`=reg, for WR_HOLD clocks → AWAIT.
  - AWAIT: `opl_cs_n`=1 for ADDR_WAIT clocks → DWR.
  - DWR: `opl_cs_n`=0, `opl_addr`=1, `opl_din`=value, for WR_HOLD clocks → DWAIT.
  - DWAIT: `opl_cs_n`=1 for DATA_WAIT clocks → IDLE.
  - A single down-counter is loaded on each state entry and the state advances when it reaches 1. A wait parameter of 0 skips that state.
- `opl_din` and `opl_addr` hold their last values outside AWR/DWR; only `opl_cs_n` qualifies them.
- **Reset.** Reset mid-operation aborts any bus cycle. The FIFO is emptied and the pairing is lost.
- **Reset values:** `opl_cs_n`=1, `opl_addr`=0, `opl_din`=0, `busy`=0, `level`=0, `overflow`=0, `led`=0, state IDLE, `phase`=0.

## Timing
- All outputs are registered.
- Second byte's `in_valid` at edge N → `level` increments at N+1.
- From a non-empty FIFO in IDLE at edge M: `opl_cs_n` falls at M+1 and stays low exactly WR_HOLD clocks.
- Address-cycle start to data-cycle start: WR_HOLD+ADDR_WAIT clocks.
- One full write occupies 2·WR_HOLD+ADDR_WAIT+DATA_WAIT+1 clocks, with the IDLE pop cycle included (defaults: 2801).
- Back-to-back pairs: the next address cycle begins one clock after DWAIT ends.
- `opl_cs_n` never glitches: it changes only at state transitions.

## Configuration
- **`OPL_WRSEQ_ACTIVITY_EN` defined:** the activity stretcher is built in.
  - Trigger: the start of a DWR cycle whose latched register is in 0xA0–0xBF (frequency/key-on writes).
  - On trigger, load an ACT_BITS counter with all-ones. `led` = counter≠0. The counter decrements each clock while nonzero, and retriggers reload it.
- **Macro not defined:** no counter logic; `led` is tied to 0.

## Test plan
- **Single write.** Send 0xA0, 0x44. Expect:
  - `opl_cs_n` low 56 clocks with `opl_addr`=0, `opl_din`=0xA0.
  - 336 clocks high.
  - 56 clocks low with `opl_addr`=1, `opl_din`=0x44.
  - 2352 clocks high, then `busy`=0.
- **Pair realignment.** Send 0x20, `in_eop`, 0xB0, 0x31. Expect exactly one write: reg 0xB0, value 0x31. `level` peaks at 1.
- **Overflow.** With FIFO_AW=2, send 6 pairs in consecutive in_valid cycles while the first is in AWR. Expect:
  - `level` saturates at 4 and `overflow`=1.
  - Exactly 5 writes on the bus: 1 popped, 4 buffered; the 6th is dropped.
- **Simultaneous push/pop.** FIFO at 1 pair and in IDLE; the second byte of a new pair arrives on the pop edge. Expect `level` remains 1 and both writes are issued in order.
- **Reset mid-write.** Assert `rst` for 1 clock during AWAIT with 3 pairs queued. Next clock: `opl_cs_n`=1, `level`=0, `overflow`=0, no further bus cycles.
- **Activity LED (with `OPL_WRSEQ_ACTIVITY_EN`, ACT_BITS=4).** Write reg 0xB0. Expect `led`=1 from DWR entry for 15 clocks, then 0. A write to reg 0x20 leaves `led`=0. Without the macro, `led` stays 0 throughout.

Source files
------------

// File: rtl/opl_write_sequencer.sv
// OPL2 write sequencer: pairs received bytes into (register, value) writes, queues them
// and replays each as an address/data bus cycle with OPL2 recovery waits. LED stretcher: OPL_WRSEQ_ACTIVITY_EN.
module opl_write_sequencer #(
  parameter int FIFO_AW   = 4,
  parameter int WR_HOLD   = 56,
  parameter int ADDR_WAIT = 336,
  parameter int DATA_WAIT = 2352,
  parameter int ACT_BITS  = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_eop,
  output logic             opl_cs_n,
  output logic             opl_addr,
  output logic [7:0]       opl_din,
  output logic             busy,
  output logic [FIFO_AW:0] level,
  output logic             overflow,
  output logic             led
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CMAX  = (WR_HOLD > ADDR_WAIT) ?
                         ((WR_HOLD > DATA_WAIT) ? WR_HOLD : DATA_WAIT) :
                         ((ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT);
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AWR   = 3'd1;
  localparam logic [2:0] S_AWAIT = 3'd2;
  localparam logic [2:0] S_DWR   = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;

  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic                phase;
  logic [7:0]          reg_byte;
  logic [15:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    level_nxt;
  logic                push, push_ok, pop, full, empty;
  logic [2:0]          state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [7:0]          cur_reg, cur_val;
  logic                dwr_entry;

  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign push      = in_valid & phase;
  assign push_ok   = push & ~full;
  assign pop       = (state == S_IDLE) & ~empty;
  assign dwr_entry = (state_nxt == S_DWR) && (state != S_DWR);

  // Byte pairing; an end-of-packet wins over the byte it accompanies.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      phase    <= 1'b0;
      reg_byte <= 8'h00;
    end else begin
      if (in_valid) begin
        if (!phase) begin
          reg_byte <= in_data;
          phase    <= 1'b1;
        end else begin
          phase    <= 1'b0;
        end
      end
      if (in_eop) phase <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointers empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= {reg_byte, in_data};
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    level_nxt = level;
    if (push_ok && !pop)      level_nxt = level + LVL_ONE;
    else if (!push_ok && pop) level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full) overflow <= 1'b1;
      level <= level_nxt;
    end
  end

  // One down-counter times every state; a zero-length wait state is bypassed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (!empty) begin
        state_nxt = S_AWR;
        cnt_nxt   = CW'(WR_HOLD);
      end
      S_AWR: if (cnt == CNT_ONE) begin
        if (ADDR_WAIT != 0) begin
          state_nxt = S_AWAIT;
          cnt_nxt   = CW'(ADDR_WAIT);
        end else begin
          state_nxt = S_DWR;
          cnt_nxt   = CW'(WR_HOLD);
        end
      end else cnt_nxt = cnt - CNT_ONE;
      S_AWAIT: if (cnt == CNT_ONE) begin
        state_nxt = S_DWR;
        cnt_nxt   = CW'(WR_HOLD);
      end else cnt_nxt = cnt - CNT_ONE;
      S_DWR: if (cnt == CNT_ONE) begin
        if (DATA_WAIT != 0) begin
          state_nxt = S_DWAIT;
          cnt_nxt   = CW'(DATA_WAIT);
        end else begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end else cnt_nxt = cnt - CNT_ONE;
      S_DWAIT: if (cnt == CNT_ONE) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt - CNT_ONE;
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opl_cs_n <= 1'b1;
      opl_addr <= 1'b0;
      opl_din  <= 8'h00;
      busy     <= 1'b0;
      cur_reg  <= 8'h00;
      cur_val  <= 8'h00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= (state_nxt != S_IDLE) || (level_nxt != '0);
      opl_cs_n <= !((state_nxt == S_AWR) || (state_nxt == S_DWR));
      if (pop) begin
        cur_reg  <= mem[rd_ptr][15:8];
        cur_val  <= mem[rd_ptr][7:0];
        opl_addr <= 1'b0;
        opl_din  <= mem[rd_ptr][15:8];
      end
      if (dwr_entry) begin
        opl_addr <= 1'b1;
        opl_din  <= cur_val;
      end
    end
  end

`ifdef OPL_WRSEQ_ACTIVITY_EN
  logic [ACT_BITS-1:0] act_cnt, act_nxt;
  logic                act_trig;

  // Frequency / key-on registers 0xA0-0xBF retrigger the stretcher.
  assign act_trig = dwr_entry && (cur_reg[7:5] == 3'b101);

  always_comb begin
    act_nxt = act_cnt;
    if (act_trig)            act_nxt = '1;
    else if (act_cnt != '0)  act_nxt = act_cnt - ACT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt <= '0;
      led     <= 1'b0;
    end else begin
      act_cnt <= act_nxt;
      led     <= (act_nxt != '0);
    end
  end
`else
  assign led = 1'b0;
`endif

endmodule

// File: tb/tb_opl_write_sequencer.sv
// Scoreboard bench for opl_write_sequencer: a timeline model predicts each write's bus
// window, level, busy, overflow and led; a negedge monitor compares against the DUT.
module tb_opl_write_sequencer;
  localparam int FIFO_AW   = 2;
  localparam int DEPTH     = 1 << FIFO_AW;
  localparam int WR_HOLD   = 56;
  localparam int ADDR_WAIT = 336;
  localparam int DATA_WAIT = 2352;
  localparam int ACT_BITS  = 4;
  localparam int TOTAL     = 2*WR_HOLD + ADDR_WAIT + DATA_WAIT + 1;
  localparam int LED_LEN   = (1 << ACT_BITS) - 1;
  localparam int INF       = 32'h7fff_ffff;
`ifdef OPL_WRSEQ_ACTIVITY_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_eop = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic opl_cs_n, opl_addr, busy, overflow, led;
  logic [7:0] opl_din;
  logic [FIFO_AW:0] level;

  opl_write_sequencer #(
    .FIFO_AW(FIFO_AW), .WR_HOLD(WR_HOLD), .ADDR_WAIT(ADDR_WAIT),
    .DATA_WAIT(DATA_WAIT), .ACT_BITS(ACT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop),
    .opl_cs_n(opl_cs_n), .opl_addr(opl_addr), .opl_din(opl_din), .busy(busy),
    .level(level), .overflow(overflow), .led(led)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int push_e;
    int pop_e;
  } item_t;

  item_t hist[$];
  item_t exp_q[$];
  int errors = 0, checks = 0, writes = 0;
  int ovf_edge = INF;
  bit m_phase = 1'b0;
  logic [7:0] m_reg = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int occ_before(input int e);
    int n = 0;
    foreach (hist[i]) if (hist[i].push_e < e && hist[i].pop_e >= e) n++;
    return n;
  endfunction

  function automatic void model_push(input logic [7:0] r, input logic [7:0] v, input int e);
    item_t it;
    if (occ_before(e) >= DEPTH) begin
      if (ovf_edge > e) ovf_edge = e;
    end else begin
      it.r = r; it.v = v; it.push_e = e;
      it.pop_e = e + 1;
      if (hist.size() != 0 && hist[$].pop_e + TOTAL > it.pop_e) it.pop_e = hist[$].pop_e + TOTAL;
      hist.push_back(it);
      exp_q.push_back(it);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit eop, input int e);
    if (!m_phase) begin
      m_reg = b;
      m_phase = 1'b1;
    end else begin
      model_push(m_reg, b, e);
      m_phase = 1'b0;
    end
    if (eop) m_phase = 1'b0;
  endfunction

  function automatic int exp_level(input int k);
    int n = 0;
    foreach (hist[i]) if (hist[i].push_e <= k && hist[i].pop_e > k) n++;
    return n;
  endfunction

  function automatic bit exp_busy(input int k);
    foreach (hist[i]) if (hist[i].push_e <= k && k <= hist[i].pop_e + TOTAL - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_led(input int k);
    int d;
    if (!LED_EN) return 1'b0;
    foreach (hist[i]) begin
      d = hist[i].pop_e + WR_HOLD + ADDR_WAIT;
      if (hist[i].r[7:5] == 3'b101 && k >= d && k < d + LED_LEN) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void exp_bus(input int k, output bit cs_n, output bit addr,
                                  output bit active, output logic [7:0] din);
    int a, d;
    cs_n = 1'b1; addr = 1'b0; active = 1'b0; din = 8'h00;
    foreach (hist[i]) begin
      a = hist[i].pop_e;
      d = a + WR_HOLD + ADDR_WAIT;
      if (k >= a && k < a + WR_HOLD) begin cs_n = 1'b0; addr = 1'b0; din = hist[i].r; active = 1'b1; end
      if (k >= d && k < d + WR_HOLD) begin cs_n = 1'b0; addr = 1'b1; din = hist[i].v; active = 1'b1; end
    end
  endfunction

  // ---------------- monitor ----------------
  bit prev_cs = 1'b1;
  logic [7:0] a_reg = 8'h00;
  int a_start = 0;

  always @(negedge clk) begin
    bit e_cs, e_addr, e_act;
    logic [7:0] e_din;
    item_t it;
    if (cyc >= 1) begin
      exp_bus(cyc, e_cs, e_addr, e_act, e_din);
      check("cs_n", opl_cs_n, e_cs);
      if (e_act) begin
        check("addr", opl_addr, e_addr);
        check("din", opl_din, e_din);
      end
      check("level", level, exp_level(cyc));
      check("busy", busy, exp_busy(cyc));
      check("overflow", overflow, (cyc >= ovf_edge));
      check("led", led, exp_led(cyc));
      if (prev_cs && !opl_cs_n) begin
        if (!opl_addr) begin
          a_reg = opl_din;
          a_start = cyc;
        end else begin
          writes++;
          check("write_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            check("wr_reg", a_reg, it.r);
            check("wr_val", opl_din, it.v);
            check("wr_start", a_start, it.pop_e);
            check("addr_to_data", cyc - a_start, WR_HOLD + ADDR_WAIT);
          end
        end
      end
      prev_cs = opl_cs_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input bit v, input bit eop);
    in_valid = v; in_data = b; in_eop = eop;
    if (v) model_byte(b, eop, cyc + 1);
    else if (eop) m_phase = 1'b0;
    step();
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] r, input logic [7:0] v);
    drive(r, 1'b1, 1'b0);
    drive(v, 1'b1, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (i < budget && (busy || exp_q.size() != 0)) begin
      step();
      i++;
    end
    check("drain_busy", busy, 0);
    check("drain_queue", exp_q.size(), 0);
    step();
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) step();
  endtask

  initial begin
    int w0, p, d;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", opl_cs_n, 1);
    check("rst_addr", opl_addr, 0);
    check("rst_din", opl_din, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_led", led, 0);
    rst = 1'b0;
    step();

    // single write
    w0 = writes;
    send_pair(8'hA0, 8'h44);
    wait_done(2 * TOTAL);
    check("single_writes", writes - w0, 1);

    // pair realignment: lone 0x20 is discarded by eop
    w0 = writes;
    drive(8'h20, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1);
    send_pair(8'hB0, 8'h31);
    wait_done(2 * TOTAL);
    check("realign_writes", writes - w0, 1);

    // overflow: six back-to-back pairs
    w0 = writes;
    for (int i = 0; i < 6; i++) send_pair(8'h40 + 8'(i), 8'h10 + 8'(i));
    check("ovf_level", level, DEPTH);
    check("ovf_flag", overflow, 1);
    wait_done(7 * TOTAL);
    check("ovf_writes", writes - w0, 5);

    // push on the pop edge with one pair stored
    w0 = writes;
    send_pair(8'h60, 8'h01);
    send_pair(8'h61, 8'h02);
    p = hist[$].pop_e;
    wait_until(p - 2);
    drive(8'h62, 1'b1, 1'b0);
    drive(8'h03, 1'b1, 1'b0);
    check("pushpop_level", level, 1);
    wait_done(4 * TOTAL);
    check("pushpop_writes", writes - w0, 3);

    // activity LED: 0xB0 stretches, 0x20 does not
    send_pair(8'hB0, 8'h21);
    p = hist[$].pop_e;
    d = p + WR_HOLD + ADDR_WAIT;
    wait_until(d);
    check("led_on", led, LED_EN);
    wait_until(d + LED_LEN);
    check("led_off", led, 0);
    wait_done(2 * TOTAL);
    send_pair(8'h20, 8'h22);
    p = hist[$].pop_e;
    wait_until(p + WR_HOLD + ADDR_WAIT + 1);
    check("led_other_reg", led, 0);
    wait_done(2 * TOTAL);

    // randomized bytes, gaps and packet boundaries
    w0 = writes;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) step();
      b = ($urandom_range(0, 1) != 0) ? 8'hA0 + 8'($urandom_range(0, 31)) : 8'($urandom);
      drive(b, 1'b1, ($urandom_range(0, 7) == 0));
    end
    wait_done(8 * TOTAL);

    // reset during AWAIT with three pairs queued
    for (int i = 0; i < 4; i++) send_pair(8'h80 + 8'(i), 8'h50 + 8'(i));
    p = hist[hist.size() - 4].pop_e;
    wait_until(p + WR_HOLD + 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    m_phase = 1'b0;
    ovf_edge = INF;
    check("mid_rst_cs_n", opl_cs_n, 1);
    check("mid_rst_level", level, 0);
    check("mid_rst_overflow", overflow, 0);
    w0 = writes;
    repeat (TOTAL + 100) step();
    check("mid_rst_no_writes", writes - w0, 0);
    check("mid_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
